// File: rtl/ram_bist_pkg.sv
// Shared types for the march BIST initiator: FSM state encoding and RAM port
// control values.
package ram_bist_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    W0      = 3'd1,
    R0W1_RD = 3'd2,
    R0W1_WR = 3'd3,
    R1      = 3'd4,
    DRAIN   = 3'd5,
    DONE_ST = 3'd6
  } bist_state_e;

  localparam logic RW_WRITE = 1'b1;
  localparam logic RW_READ  = 1'b0;

endpackage

// File: rtl/bist_addr_ctr.sv
// Up/down address counter with synchronous load and enable.
// The terminal-count flag marks the last address in the current direction.
module bist_addr_ctr #(
  parameter int ADDR_W = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_load,
  input  logic [ADDR_W-1:0] i_load_val,
  input  logic              i_en,
  input  logic              i_up,
  output logic [ADDR_W-1:0] o_count,
  output logic              o_tc
);

  logic [ADDR_W-1:0] r_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (i_en) begin
      r_count <= i_up ? r_count + 1'b1 : r_count - 1'b1;
    end
  end

  assign o_count = r_count;
  assign o_tc    = i_up ? (r_count == '1) : (r_count == '0);

endmodule

// File: rtl/ram_march_bist.sv
// March BIST initiator: W0(pattern, up), R0W1(read pattern / write inverse, up),
// R1(read inverse, down) with first-failure capture and abort.
module ram_march_bist
  import ram_bist_pkg::*;
#(
  parameter int                 ADDR_W  = 2,
  parameter int                 DATA_W  = 4,
  parameter logic [DATA_W-1:0]  PATTERN = 4'b1010
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic              R_W,
  output logic [ADDR_W-1:0] address,
  output logic [DATA_W-1:0] data_out,
  input  logic [DATA_W-1:0] data_in,
  output logic              busy,
  output logic              done,
  output logic              fail,
  output logic [ADDR_W-1:0] fail_addr,
  output logic [DATA_W-1:0] fail_data
);

  localparam logic [DATA_W-1:0] INV_PATTERN = ~PATTERN;

  bist_state_e       r_state;
  bist_state_e       w_state_next;
  logic              r_fail;
  logic [ADDR_W-1:0] r_fail_addr;
  logic [DATA_W-1:0] r_fail_data;

  logic              w_load;
  logic [ADDR_W-1:0] w_load_val;
  logic              w_en;
  logic              w_up;
  logic [ADDR_W-1:0] w_addr;
  logic              w_tc;
  logic              w_latch;
  logic [ADDR_W-1:0] w_cand_addr;
  logic              w_accept;

  // Only R1 walks downward; keeping this out of the FSM process avoids a
  // combinational path from the direction back through the tc flag.
  assign w_up     = (r_state != R1);
  assign w_accept = start && ((r_state == IDLE) || (r_state == DONE_ST));

  bist_addr_ctr #(.ADDR_W(ADDR_W)) u_addr_ctr (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_load     (w_load),
    .i_load_val (w_load_val),
    .i_en       (w_en),
    .i_up       (w_up),
    .o_count    (w_addr),
    .o_tc       (w_tc)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_fail      <= 1'b0;
      r_fail_addr <= '0;
      r_fail_data <= '0;
    end else begin
      r_state <= w_state_next;
      if (w_accept) begin
        r_fail      <= 1'b0;
        r_fail_addr <= '0;
        r_fail_data <= '0;
      end else if (w_latch && !r_fail) begin
        r_fail      <= 1'b1;
        r_fail_addr <= w_cand_addr;
        r_fail_data <= data_in;
      end
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_load       = 1'b0;
    w_load_val   = '0;
    w_en         = 1'b0;
    w_latch      = 1'b0;
    w_cand_addr  = w_addr;
    R_W          = RW_READ;
    address      = '0;
    data_out     = '0;
    case (r_state)
      IDLE, DONE_ST: begin
        if (start) begin
          w_state_next = W0;
          w_load       = 1'b1;
        end
      end
      W0: begin
        R_W      = RW_WRITE;
        address  = w_addr;
        data_out = PATTERN;
        if (w_tc) begin
          w_state_next = R0W1_RD;
          w_load       = 1'b1;
        end else begin
          w_en = 1'b1;
        end
      end
      R0W1_RD: begin
        address      = w_addr;
        w_state_next = R0W1_WR;
      end
      R0W1_WR: begin
        address = w_addr;
        // A mismatch suppresses this sub-cycle's write and aborts.
        if (data_in != PATTERN) begin
          w_latch      = 1'b1;
          w_state_next = DONE_ST;
        end else begin
          R_W      = RW_WRITE;
          data_out = INV_PATTERN;
          if (w_tc) begin
            w_state_next = R1;
            w_load       = 1'b1;
            w_load_val   = '1;
          end else begin
            w_en         = 1'b1;
            w_state_next = R0W1_RD;
          end
        end
      end
      R1: begin
        address = w_addr;
        // data_in belongs to the previous read (address + 1); none on the first cycle.
        if ((w_addr != '1) && (data_in != INV_PATTERN)) begin
          w_latch      = 1'b1;
          w_cand_addr  = w_addr + 1'b1;
          w_state_next = DONE_ST;
        end else if (w_tc) begin
          w_state_next = DRAIN;
        end else begin
          w_en = 1'b1;
        end
      end
      DRAIN: begin
        if (data_in != INV_PATTERN) begin
          w_latch     = 1'b1;
          w_cand_addr = '0;
        end
        w_state_next = DONE_ST;
      end
      default: w_state_next = IDLE;
    endcase
  end

  assign busy      = (r_state != IDLE) && (r_state != DONE_ST);
  assign done      = (r_state == DONE_ST);
  assign fail      = r_fail;
  assign fail_addr = r_fail_addr;
  assign fail_data = r_fail_data;

endmodule

// File: tb/tb_ram_march_bist.sv
// Bench for ram_march_bist: 4x4 RAM model with selectable faults, vector table
// of whole runs plus hand sequences for restart, re-run and mid-run reset.
module tb_ram_march_bist;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic       R_W;
  logic [1:0] address;
  logic [3:0] data_out;
  logic [3:0] data_in;
  logic       busy;
  logic       done;
  logic       fail;
  logic [1:0] fail_addr;
  logic [3:0] fail_data;

  int n_tests = 0;
  int n_fail  = 0;

  ram_march_bist #(.ADDR_W(2), .DATA_W(4), .PATTERN(4'b1010)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .R_W       (R_W),
    .address   (address),
    .data_out  (data_out),
    .data_in   (data_in),
    .busy      (busy),
    .done      (done),
    .fail      (fail),
    .fail_addr (fail_addr),
    .fail_data (fail_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM model: sync write, registered read. fault_mode 2: bit0 of addr 2
  // reads as 0; 3: addr 1 ignores writes of 0101; 4: addr 1010 writes to
  // addr 3 store 0000.
  int         fault_mode = 0;
  logic       clr_mem = 1'b0;
  logic [3:0] mem [4];
  logic [3:0] ram_q;
  logic [1:0] rd_a;
  logic       ram_we;
  logic [3:0] ram_wd;

  assign ram_we  = R_W && !(fault_mode == 3 && address == 2'd1 && data_out == 4'b0101);
  assign ram_wd  = (fault_mode == 4 && address == 2'd3 && data_out == 4'b1010) ? 4'b0000 : data_out;
  assign data_in = (fault_mode == 2 && rd_a == 2'd2) ? (ram_q & 4'b1110) : ram_q;

  always @(posedge clk) begin
    if (clr_mem) begin
      for (int i = 0; i < 4; i++) mem[i] <= 4'b0000;
    end else if (ram_we) begin
      mem[address] <= ram_wd;
    end
    ram_q <= mem[address];
    rd_a  <= address;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic clear_mem();
    @(negedge clk); clr_mem = 1'b1;
    @(negedge clk); clr_mem = 1'b0;
  endtask

  // Pulse start, then count busy cycles until done. restart_at re-pulses
  // start after that many busy cycles.
  task automatic run_bist(input int restart_at, output int cycles, output logic first_done);
    int guard;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    first_done = done;
    cycles = 0;
    guard  = 0;
    while (!done && guard < 200) begin
      if (busy) cycles++;
      start = (cycles == restart_at);
      @(negedge clk);
      guard++;
    end
    start = 1'b0;
    chk("run_reached_done", done, 1);
  endtask

  typedef struct {
    int         fault;
    logic       exp_fail;
    logic [1:0] exp_faddr;
    logic [3:0] exp_fdata;
    int         exp_cycles;
    logic [15:0] exp_mem;
  } vec_t;

  vec_t vecs[4];
  int   cyc;
  logic fd;

  initial begin
    vecs[0] = '{0, 1'b0, 2'd0, 4'h0, 17, 16'h5555};
    vecs[1] = '{2, 1'b1, 2'd2, 4'h4, 15, 16'h5555};
    vecs[2] = '{3, 1'b1, 2'd1, 4'hA, 16, 16'h55A5};
    vecs[3] = '{4, 1'b1, 2'd3, 4'h0, 12, 16'h0555};

    rst_n = 1'b0;
    start = 1'b0;
    #12;
    chk("reset_R_W", R_W, 0);
    chk("reset_address", address, 0);
    chk("reset_data_out", data_out, 0);
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_fail", fail, 0);
    chk("reset_fail_addr", fail_addr, 0);
    chk("reset_fail_data", fail_data, 0);
    #8;
    rst_n = 1'b1;

    for (int v = 0; v < 4; v++) begin
      fault_mode = vecs[v].fault;
      clear_mem();
      run_bist(-1, cyc, fd);
      chk($sformatf("v%0d_cycles", v), cyc, vecs[v].exp_cycles);
      chk($sformatf("v%0d_fail", v), fail, vecs[v].exp_fail);
      if (vecs[v].exp_fail) begin
        chk($sformatf("v%0d_fail_addr", v), fail_addr, vecs[v].exp_faddr);
        chk($sformatf("v%0d_fail_data", v), fail_data, vecs[v].exp_fdata);
      end
      chk($sformatf("v%0d_mem", v), {mem[3], mem[2], mem[1], mem[0]}, vecs[v].exp_mem);
      chk($sformatf("v%0d_idle_R_W", v), R_W, 0);
      $display("[TB] vector %0d fault=%0d cycles=%0d fail=%0b fail_addr=%0d fail_data=%h",
               v, vecs[v].fault, cyc, fail, fail_addr, fail_data);
    end

    // start while busy is ignored
    fault_mode = 0;
    clear_mem();
    run_bist(3, cyc, fd);
    chk("restart_ignored_cycles", cyc, 17);
    chk("restart_ignored_fail", fail, 0);
    $display("[TB] restart-while-busy cycles=%0d fail=%0b", cyc, fail);

    // start from DONE_ST: done drops next cycle, second run passes
    run_bist(-1, cyc, fd);
    chk("rerun_done_cleared", fd, 0);
    chk("rerun_cycles", cyc, 17);
    chk("rerun_fail", fail, 0);
    $display("[TB] rerun from done cycles=%0d fail=%0b", cyc, fail);

    // async reset during busy cycle 6 (R0W1 write of address 0)
    clear_mem();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (5) @(negedge clk);
    chk("pre_reset_R_W", R_W, 1);
    chk("pre_reset_data_out", data_out, 4'b0101);
    #2 rst_n = 1'b0;
    #1;
    chk("async_reset_R_W", R_W, 0);
    chk("async_reset_busy", busy, 0);
    chk("async_reset_address", address, 0);
    chk("async_reset_data_out", data_out, 0);
    chk("async_reset_done", done, 0);
    @(negedge clk);
    chk("reset_no_write_mem1", mem[1], 4'b1010);
    rst_n = 1'b1;
    $display("[TB] mid-run reset R_W=%0b busy=%0b", R_W, busy);
    clear_mem();
    run_bist(-1, cyc, fd);
    chk("post_reset_cycles", cyc, 17);
    chk("post_reset_fail", fail, 0);
    chk("post_reset_mem", {mem[3], mem[2], mem[1], mem[0]}, 16'h5555);
    $display("[TB] post-reset run cycles=%0d fail=%0b", cyc, fail);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
